// File: rtl/mipi_csi_rx_packet_ctrl_4lane.sv
// Purpose: CSI-2 packet sequencer; parses headers, gates long-packet payload to the depacker, tracks frame/line state.
// Latency: data_i to payload_o is 1 clock; the header word is never forwarded.
// Backpressure: none; the depacker always accepts, so words are consumed every valid cycle.
module mipi_csi_rx_packet_ctrl_4lane #(
    parameter logic [1:0] VC_ID    = 2'd0,
    parameter int         WC_WIDTH = 16
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        data_valid_i,
    input  logic [31:0] data_i,
    output logic        payload_valid_o,
    output logic [31:0] payload_o,
    output logic [2:0]  packet_type_o,
    output logic        frame_valid_o,
    output logic        line_start_o,
    output logic [15:0] line_count_o,
    output logic        err_dt_o,
    output logic        err_trunc_o
);

    localparam int RW = WC_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        SKIP    = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [RW-1:0]       remaining, remaining_nxt;
    logic                payload_valid_nxt;
    logic [31:0]         payload_nxt;
    logic [2:0]          packet_type_nxt;
    logic                frame_valid_nxt;
    logic                line_start_nxt;
    logic [15:0]         line_count_nxt;
    logic                err_dt_nxt;
    logic                err_trunc_nxt;

    logic [5:0]          hdr_dt;
    logic [1:0]          hdr_vc;
    logic [WC_WIDTH-1:0] hdr_wc;
    logic [WC_WIDTH:0]   wc_round;
    logic [RW-1:0]       hdr_words;
    logic                dt_raw;

    assign hdr_dt    = data_i[5:0];
    assign hdr_vc    = data_i[7:6];
    assign hdr_wc    = data_i[8 +: WC_WIDTH];
    // Payload length in 32-bit words, rounded up; the last word may be partial.
    assign wc_round  = {1'b0, hdr_wc} + (WC_WIDTH+1)'(3);
    assign hdr_words = wc_round[WC_WIDTH:2];
    assign dt_raw    = (hdr_dt >= 6'h2A) && (hdr_dt <= 6'h2E);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state           <= IDLE;
            remaining       <= '0;
            payload_valid_o <= 1'b0;
            payload_o       <= '0;
            packet_type_o   <= 3'd2;
            frame_valid_o   <= 1'b0;
            line_start_o    <= 1'b0;
            line_count_o    <= '0;
            err_dt_o        <= 1'b0;
            err_trunc_o     <= 1'b0;
        end else begin
            state           <= state_nxt;
            remaining       <= remaining_nxt;
            payload_valid_o <= payload_valid_nxt;
            payload_o       <= payload_nxt;
            packet_type_o   <= packet_type_nxt;
            frame_valid_o   <= frame_valid_nxt;
            line_start_o    <= line_start_nxt;
            line_count_o    <= line_count_nxt;
            err_dt_o        <= err_dt_nxt;
            err_trunc_o     <= err_trunc_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        remaining_nxt     = remaining;
        payload_valid_nxt = 1'b0;
        payload_nxt       = payload_o;
        packet_type_nxt   = packet_type_o;
        frame_valid_nxt   = frame_valid_o;
        line_start_nxt    = 1'b0;
        line_count_nxt    = line_count_o;
        err_dt_nxt        = 1'b0;
        err_trunc_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (data_valid_i) begin
                    state_nxt = SKIP;
                    if (hdr_vc != VC_ID) begin
                        state_nxt = SKIP;
                    end else if (hdr_dt < 6'h10) begin
                        if (hdr_dt == 6'h00) begin
                            frame_valid_nxt = 1'b1;
                            line_count_nxt  = '0;
                        end else if (hdr_dt == 6'h01) begin
                            frame_valid_nxt = 1'b0;
                        end
                    end else if (dt_raw) begin
                        packet_type_nxt = hdr_dt[2:0];
                        line_start_nxt  = 1'b1;
                        if (line_count_o != 16'hFFFF) begin
                            line_count_nxt = line_count_o + 16'd1;
                        end
                        // An empty line is still counted but has nothing to forward.
                        if (hdr_wc != '0) begin
                            remaining_nxt = hdr_words;
                            state_nxt     = PAYLOAD;
                        end
                    end else begin
                        err_dt_nxt = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (data_valid_i) begin
                    payload_nxt       = data_i;
                    payload_valid_nxt = 1'b1;
                    remaining_nxt     = remaining - RW'(1);
                    if (remaining == RW'(1)) begin
                        state_nxt = SKIP;
                    end
                end else begin
                    err_trunc_nxt = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            SKIP: begin
                // Trailing CRC and filler are dropped; the idle cycle resyncs the depacker.
                if (!data_valid_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mipi_csi_rx_packet_ctrl_4lane.sv
// Scoreboard bench for the CSI-2 packet sequencer: directed packets push expectations, a negedge monitor pops them.
module tb_mipi_csi_rx_packet_ctrl_4lane;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        data_valid_i;
    logic [31:0] data_i;
    logic        payload_valid_o;
    logic [31:0] payload_o;
    logic [2:0]  packet_type_o;
    logic        frame_valid_o;
    logic        line_start_o;
    logic [15:0] line_count_o;
    logic        err_dt_o;
    logic        err_trunc_o;

    mipi_csi_rx_packet_ctrl_4lane #(.VC_ID(2'd0), .WC_WIDTH(16)) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .data_valid_i    (data_valid_i),
        .data_i          (data_i),
        .payload_valid_o (payload_valid_o),
        .payload_o       (payload_o),
        .packet_type_o   (packet_type_o),
        .frame_valid_o   (frame_valid_o),
        .line_start_o    (line_start_o),
        .line_count_o    (line_count_o),
        .err_dt_o        (err_dt_o),
        .err_trunc_o     (err_trunc_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          cyc;
        logic [2:0]  pt;
        logic [31:0] d;
    } pay_t;

    pay_t        pay_q[$];
    int          run_q[$];
    int          lc_q[$];
    int          dt_q[$];
    int          tr_q[$];
    logic [31:0] wbuf[16];
    int          cyc = 0;
    int          run = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every DUT output event is matched against the head of its queue.
    always @(negedge clk_i) begin
        pay_t e;
        int   v;
        if (payload_valid_o) begin
            run++;
            chk("payload_expected", 32'(pay_q.size() != 0), 32'd1);
            if (pay_q.size() != 0) begin
                e = pay_q.pop_front();
                chk("payload_data", payload_o, e.d);
                chk("payload_type", 32'(packet_type_o), 32'(e.pt));
                chk("payload_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (run > 0) begin
            chk("run_expected", 32'(run_q.size() != 0), 32'd1);
            if (run_q.size() != 0) begin
                v = run_q.pop_front();
                chk("payload_run_len", 32'(run), 32'(v));
            end
            run = 0;
        end
        if (line_start_o) begin
            chk("line_start_expected", 32'(lc_q.size() != 0), 32'd1);
            if (lc_q.size() != 0) begin
                v = lc_q.pop_front();
                chk("line_count_at_start", 32'(line_count_o), 32'(v));
            end
        end
        if (err_dt_o) begin
            chk("err_dt_expected", 32'(dt_q.size() != 0), 32'd1);
            if (dt_q.size() != 0) begin
                v = dt_q.pop_front();
                chk("err_dt_cycle", 32'(cyc), 32'(v));
            end
        end
        if (err_trunc_o) begin
            chk("err_trunc_expected", 32'(tr_q.size() != 0), 32'd1);
            if (tr_q.size() != 0) begin
                v = tr_q.pop_front();
                chk("err_trunc_cycle", 32'(cyc), 32'(v));
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] d);
        @(posedge clk_i);
        #1;
        data_valid_i = v;
        data_i       = d;
    endtask

    // hdr, words after header, expected forwarded words, expected type, expected count at line_start (-1: none)
    task automatic send(input logic [31:0] hdr, input int nw, input int nfwd, input logic [2:0] pt,
                        input int exp_lc, input bit exp_dt, input bit exp_tr);
        pay_t e;
        drive(1'b1, hdr);
        if (exp_lc >= 0) lc_q.push_back(exp_lc);
        if (exp_dt) dt_q.push_back(cyc + 1);
        for (int i = 0; i < nw; i++) begin
            drive(1'b1, wbuf[i]);
            if (i < nfwd) begin
                e.cyc = cyc + 1;
                e.pt  = pt;
                e.d   = wbuf[i];
                pay_q.push_back(e);
            end
        end
        if (nfwd > 0) run_q.push_back(nfwd);
        drive(1'b0, 32'h0);
        if (exp_tr) tr_q.push_back(cyc + 1);
    endtask

    task automatic fill_raw10(input int line);
        for (int i = 0; i < 5; i++) wbuf[i] = 32'h1000_0000 + 32'(line * 16 + i);
        wbuf[5] = 32'h0000_5A5A;
    endtask

    initial begin
        pay_t e;
        reset_n_i    = 1'b0;
        data_valid_i = 1'b0;
        data_i       = 32'h0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_payload_valid", 32'(payload_valid_o), 32'd0);
        chk("rst_payload", payload_o, 32'h0);
        chk("rst_packet_type", 32'(packet_type_o), 32'd2);
        chk("rst_frame_valid", 32'(frame_valid_o), 32'd0);
        chk("rst_line_count", 32'(line_count_o), 32'd0);
        chk("rst_pulses", 32'({line_start_o, err_dt_o, err_trunc_o}), 32'd0);
        reset_n_i = 1'b1;
        drive(1'b0, 32'h0);

        // FS then one RAW14 line of 16 pixels (WC 28 -> 7 words) plus CRC
        send(32'h0001_0000, 0, 0, 3'd0, -1, 1'b0, 1'b0);
        chk("fs_frame_valid", 32'(frame_valid_o), 32'd1);
        wbuf[0] = 32'h04030201; wbuf[1] = 32'h05000000; wbuf[2] = 32'h00080706;
        wbuf[3] = 32'h0A090000; wbuf[4] = 32'h00000C0B; wbuf[5] = 32'h0F0E0D00;
        wbuf[6] = 32'h00000011; wbuf[7] = 32'h0000ABCD;
        send(32'h0000_1C2D, 8, 7, 3'd5, 1, 1'b0, 1'b0);
        chk("raw14_packet_type", 32'(packet_type_o), 32'd5);
        chk("raw14_line_count", 32'(line_count_o), 32'd1);

        // Fresh frame, three back-to-back RAW10 lines (WC 20 -> 5 words)
        send(32'h0002_0000, 0, 0, 3'd0, -1, 1'b0, 1'b0);
        chk("fs2_line_count", 32'(line_count_o), 32'd0);
        for (int l = 0; l < 3; l++) begin
            fill_raw10(l);
            send(32'h0000_142B, 6, 5, 3'd3, l + 1, 1'b0, 1'b0);
        end
        chk("raw10_line_count", 32'(line_count_o), 32'd3);
        chk("raw10_packet_type", 32'(packet_type_o), 32'd3);
        send(32'h0002_0001, 0, 0, 3'd0, -1, 1'b0, 1'b0);
        chk("fe_frame_valid", 32'(frame_valid_o), 32'd0);
        chk("fe_line_count_held", 32'(line_count_o), 32'd3);
        send(32'h0003_0000, 0, 0, 3'd0, -1, 1'b0, 1'b0);
        chk("fs3_frame_valid", 32'(frame_valid_o), 32'd1);
        chk("fs3_line_count", 32'(line_count_o), 32'd0);

        // RAW12 on VC1 is skipped; RGB888 raises err_dt
        for (int i = 0; i < 5; i++) wbuf[i] = 32'hDEAD_0000 + 32'(i);
        send(32'h0000_106C, 5, 0, 3'd0, -1, 1'b0, 1'b0);
        chk("vc1_line_count", 32'(line_count_o), 32'd0);
        chk("vc1_packet_type", 32'(packet_type_o), 32'd3);
        send(32'h0000_0C24, 4, 0, 3'd0, -1, 1'b1, 1'b0);
        chk("rgb_line_count", 32'(line_count_o), 32'd0);

        // RAW8 WC16 truncated after 2 words, then a normal RAW10 line
        wbuf[0] = 32'h44332211; wbuf[1] = 32'h88776655;
        send(32'h0000_102A, 2, 2, 3'd2, 1, 1'b0, 1'b1);
        chk("trunc_packet_type", 32'(packet_type_o), 32'd2);
        fill_raw10(7);
        send(32'h0000_142B, 6, 5, 3'd3, 2, 1'b0, 1'b0);
        chk("post_trunc_line_count", 32'(line_count_o), 32'd2);

        // Asynchronous reset in the middle of a RAW8 payload
        drive(1'b1, 32'h0000_102A);
        lc_q.push_back(3);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'hCAFE_0000 + 32'(i));
            e.cyc = cyc + 1;
            e.pt  = 3'd2;
            e.d   = 32'hCAFE_0000 + 32'(i);
            pay_q.push_back(e);
        end
        run_q.push_back(2);
        @(posedge clk_i);
        #7;
        chk("pre_rst_payload_valid", 32'(payload_valid_o), 32'd1);
        reset_n_i    = 1'b0;
        data_valid_i = 1'b0;
        data_i       = 32'h0;
        #1;
        chk("arst_payload_valid", 32'(payload_valid_o), 32'd0);
        chk("arst_payload", payload_o, 32'h0);
        chk("arst_frame_valid", 32'(frame_valid_o), 32'd0);
        chk("arst_line_count", 32'(line_count_o), 32'd0);
        chk("arst_packet_type", 32'(packet_type_o), 32'd2);
        repeat (2) @(posedge clk_i);
        #3;
        reset_n_i = 1'b1;
        drive(1'b0, 32'h0);
        send(32'h0004_0000, 0, 0, 3'd0, -1, 1'b0, 1'b0);
        chk("restart_frame_valid", 32'(frame_valid_o), 32'd1);
        chk("restart_line_count", 32'(line_count_o), 32'd0);
        fill_raw10(9);
        send(32'h0000_142B, 6, 5, 3'd3, 1, 1'b0, 1'b0);

        repeat (4) drive(1'b0, 32'h0);
        chk("pay_q_drained", 32'(pay_q.size()), 32'd0);
        chk("run_q_drained", 32'(run_q.size()), 32'd0);
        chk("lc_q_drained", 32'(lc_q.size()), 32'd0);
        chk("dt_q_drained", 32'(dt_q.size()), 32'd0);
        chk("tr_q_drained", 32'(tr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
